// File: rtl/branch_resolve.sv
// Conditional branch resolver at the Decode/Execute boundary.
// Evaluates cond against the flags, issues a redirect, and stalls on pending flag writes.
module branch_resolve #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  input  logic              br_reg,
  input  logic [2:0]        cond,
  input  logic [8:0]        imm9,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_v,
  input  logic              ex_flag_wr,
  output logic              br_stall,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic              l_reg;
  logic [2:0]        l_cond;
  logic [8:0]        l_imm;
  logic [DATA_W-1:0] l_pc;
  logic [DATA_W-1:0] l_rs;

  logic              s_reg;
  logic [2:0]        s_cond;
  logic [8:0]        s_imm;
  logic [DATA_W-1:0] s_pc;
  logic [DATA_W-1:0] s_rs;

  logic              taken;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] offset;
  logic              hazard;
  logic              resolve;
  logic              latch;

  // Operand select: a waiting branch uses its latched copy
  always_comb begin
    s_reg  = br_reg;
    s_cond = cond;
    s_imm  = imm9;
    s_pc   = pc_plus2;
    s_rs   = rs_data;
    if (state == WAIT) begin
      s_reg  = l_reg;
      s_cond = l_cond;
      s_imm  = l_imm;
      s_pc   = l_pc;
      s_rs   = l_rs;
    end
  end

  // Condition evaluation against the live flag register
  always_comb begin
    taken = 1'b0;
    unique case (s_cond)
      3'b000: taken = ~flag_z;
      3'b001: taken = flag_z;
      3'b010: taken = ~flag_z & ~flag_n;
      3'b011: taken = flag_n;
      3'b100: taken = flag_z | (~flag_z & ~flag_n);
      3'b101: taken = flag_n | flag_z;
      3'b110: taken = flag_v;
      3'b111: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Target: word offset doubled, wraps silently
  always_comb begin
    offset = {{(DATA_W-10){s_imm[8]}}, s_imm, 1'b0};
    target = s_reg ? s_rs : (s_pc + offset);
  end

  assign hazard = (cond != 3'b111) & ex_flag_wr;

  // Next state, combinational stall and resolve strobe
  always_comb begin
    state_nx = state;
    br_stall = 1'b0;
    resolve  = 1'b0;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (br_valid) begin
          if (hazard) begin
            br_stall = 1'b1;
            latch    = 1'b1;
            state_nx = WAIT;
          end else begin
            resolve  = 1'b1;
            state_nx = taken ? FLUSH : IDLE;
          end
        end
      end
      WAIT: begin
        br_stall = 1'b1;
        resolve  = 1'b1;
        state_nx = taken ? FLUSH : IDLE;
      end
      FLUSH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture operands of a branch held behind a flag write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg  <= 1'b0;
      l_cond <= 3'd0;
      l_imm  <= 9'd0;
      l_pc   <= '0;
      l_rs   <= '0;
    end else if (latch) begin
      l_reg  <= br_reg;
      l_cond <= cond;
      l_imm  <= imm9;
      l_pc   <= pc_plus2;
      l_rs   <= rs_data;
    end
  end

  // Registered one-cycle redirect pulse and its target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= resolve & taken;
      if (resolve & taken) begin
        redirect_pc <= target;
      end
    end
  end

  // Saturating statistics, bumped on the resolving edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (resolve) begin
      if (~&br_count) begin
        br_count <= br_count + 1'b1;
      end
      if (taken & ~&taken_count) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed plan items then random traffic
// against a transaction-level reference model.
module tb_branch_resolve;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              br_valid;
  logic              br_reg;
  logic [2:0]        cond;
  logic [8:0]        imm9;
  logic [DATA_W-1:0] pc_plus2;
  logic [DATA_W-1:0] rs_data;
  logic              flag_z;
  logic              flag_n;
  logic              flag_v;
  logic              ex_flag_wr;
  logic              br_stall;
  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  int checks = 0;
  int errors = 0;

  branch_resolve #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_reg(br_reg),
    .cond(cond), .imm9(imm9),
    .pc_plus2(pc_plus2), .rs_data(rs_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .ex_flag_wr(ex_flag_wr),
    .br_stall(br_stall), .redirect(redirect),
    .redirect_pc(redirect_pc),
    .br_count(br_count), .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one pending branch, one flush slot, two counters
  int m_br;
  int m_tk;
  bit m_redir;
  int m_rpc;
  bit m_pend;
  bit m_flush;
  bit p_reg;
  int p_cond;
  int p_imm;
  int p_pc;
  int p_rs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit holds(input int c, input bit z, input bit n,
                               input bit v);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int dest(input bit r, input int imm, input int pc,
                              input int rs);
    int s;
    if (r) return rs;
    s = (imm >= 256) ? imm - 512 : imm;
    return (pc + s * 2) & 16'hFFFF;
  endfunction

  task automatic m_reset();
    m_br = 0; m_tk = 0; m_redir = 0; m_rpc = 0;
    m_pend = 0; m_flush = 0;
  endtask

  task automatic m_resolve(input bit r, input int c, input int imm,
                           input int pc, input int rs);
    bit t;
    t = holds(c, flag_z, flag_n, flag_v);
    if (m_br < CMAX) m_br++;
    if (t) begin
      if (m_tk < CMAX) m_tk++;
      m_redir = 1;
      m_rpc = dest(r, imm, pc, rs);
      m_flush = 1;
    end
  endtask

  task automatic m_edge();
    m_redir = 0;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_pend) begin
      m_pend = 0;
      m_resolve(p_reg, p_cond, p_imm, p_pc, p_rs);
    end else if (br_valid) begin
      if (cond != 3'b111 && ex_flag_wr) begin
        m_pend = 1;
        p_reg = br_reg; p_cond = int'(cond); p_imm = int'(imm9);
        p_pc = int'(pc_plus2); p_rs = int'(rs_data);
      end else begin
        m_resolve(br_reg, int'(cond), int'(imm9), int'(pc_plus2),
                  int'(rs_data));
      end
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".redir"}, 32'(redirect), 32'(m_redir));
    if (m_redir) chk({tag, ".pc"}, 32'(redirect_pc), 32'(m_rpc));
    chk({tag, ".brc"}, 32'(br_count), 32'(m_br));
    chk({tag, ".tkc"}, 32'(taken_count), 32'(m_tk));
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cyc(input string tag);
    bit st;
    #1;
    st = m_pend || (!m_flush && br_valid && cond != 3'b111 && ex_flag_wr);
    chk({tag, ".stall"}, 32'(br_stall), 32'(st));
    @(posedge clk);
    m_edge();
    #1;
    chk_out(tag);
    @(negedge clk);
  endtask

  task automatic idle_in();
    br_valid = 0; br_reg = 0; cond = 0; imm9 = 0; pc_plus2 = 0;
    rs_data = 0; flag_z = 0; flag_n = 0; flag_v = 0; ex_flag_wr = 0;
  endtask

  task automatic br_in(input bit r, input logic [2:0] c,
                       input logic [8:0] imm, input logic [15:0] pc,
                       input logic [15:0] rs, input bit ex);
    br_valid = 1; br_reg = r; cond = c; imm9 = imm;
    pc_plus2 = pc; rs_data = rs; ex_flag_wr = ex;
  endtask

  initial begin
    idle_in();
    m_reset();
    rst_n = 0;
    #1;
    chk("rst.stall", 32'(br_stall), 0);
    chk("rst.pc", 32'(redirect_pc), 0);
    chk_out("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 5; i++) cyc("idle");

    br_in(0, 3'b001, 9'h1FE, 16'h0010, 16'h0, 0);
    flag_z = 1;
    cyc("beq");
    chk("beq.pc_c", 32'(redirect_pc), 32'h000C);
    idle_in();
    cyc("beq2");

    br_in(1, 3'b011, 9'h0, 16'h0100, 16'h1234, 0);
    flag_n = 0;
    cyc("brlt");
    idle_in();

    br_in(0, 3'b000, 9'h004, 16'h0200, 16'h0, 1);
    flag_z = 1;
    cyc("haz0");
    idle_in();
    flag_z = 0;
    cyc("haz1");
    cyc("haz2");
    chk("haz.pc_c", 32'(redirect_pc), 32'h0208);
    cyc("haz3");

    br_in(0, 3'b111, 9'h002, 16'hFFFE, 16'h0, 1);
    cyc("wrap");
    chk("wrap.pc_c", 32'(redirect_pc), 32'h0002);
    br_in(0, 3'b111, 9'h010, 16'h0040, 16'h0, 0);
    cyc("flushbv");
    idle_in();
    cyc("post");

    br_in(0, 3'b110, 9'h020, 16'h0300, 16'h0, 1);
    flag_v = 1;
    cyc("rw0");
    rst_n = 0;
    m_reset();
    #1;
    chk_out("rstwait");
    @(negedge clk);
    rst_n = 1;
    idle_in();
    for (int i = 0; i < 3; i++) cyc("rstpost");

    for (int i = 0; i < 700; i++) begin
      br_valid   = ($urandom_range(0, 9) < 7);
      br_reg     = $urandom_range(0, 1);
      cond       = 3'($urandom_range(0, 7));
      imm9       = 9'($urandom);
      pc_plus2   = 16'($urandom) & 16'hFFFE;
      rs_data    = 16'($urandom);
      flag_z     = $urandom_range(0, 1);
      flag_n     = $urandom_range(0, 1);
      flag_v     = $urandom_range(0, 1);
      ex_flag_wr = ($urandom_range(0, 9) < 4);
      if (i > 600) begin
        cond = 3'b111;
        ex_flag_wr = 0;
      end
      cyc("rnd");
    end
    chk("sat.brc", 32'(br_count), CMAX);
    chk("sat.tkc", 32'(taken_count), CMAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
